// File: rtl/csi_encoder.sv
// csi_encoder: turns a {opcode, parameter} command into a terminal CSI
// byte sequence  ESC '[' [decimal digits] <final>  on a valid/ready byte stream.
// Build option: define CSI_ENCODER_PARAM_EN to emit the decimal parameter;
// without it every sequence is ESC '[' <final>, except opcode 13 (ESC [ 3 ~).
module csi_encoder (
    input  logic       clk,
    input  logic       _rst,
    input  logic       cmd_valid,
    input  logic [3:0] cmd_op,
    input  logic [6:0] cmd_param,
    output logic       cmd_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy,
    output logic       done,
    output logic       err
);

    typedef enum logic [2:0] {IDLE, ESC, BRK, HUND, TENS, ONES, FINAL} state_t;

    localparam logic [7:0] ASCII_ESC   = 8'd27;
    localparam logic [7:0] ASCII_BRK   = 8'd91;
    localparam logic [7:0] ASCII_ZERO  = 8'd48;
    localparam logic [7:0] ASCII_THREE = 8'd51;
    localparam logic [3:0] OP_DEL      = 4'd13;

    state_t     state;
    logic [7:0] final_q;   // final byte of the accepted command
    logic [7:0] ones_q;    // last digit byte
    logic [1:0] ndig_q;    // number of digit bytes still to be emitted after '['
    logic [7:0] final_w;
    logic [7:0] ones_w;
    logic [1:0] ndig_w;
    logic       reserved_w;

    // Final-byte lookup; reserved opcodes never reach the FINAL state.
    function automatic logic [7:0] final_byte(input logic [3:0] op);
        case (op)
            4'd0:    return 8'd67;   // C
            4'd1:    return 8'd68;   // D
            4'd2:    return 8'd69;   // E
            4'd3:    return 8'd70;   // F
            4'd4:    return 8'd71;   // G
            4'd5:    return 8'd72;   // H
            4'd6:    return 8'd74;   // J
            4'd7:    return 8'd75;   // K
            4'd8:    return 8'd83;   // S
            4'd9:    return 8'd84;   // T
            4'd10:   return 8'd102;  // f
            4'd11:   return 8'd115;  // s
            4'd12:   return 8'd117;  // u
            4'd13:   return 8'd126;  // ~
            default: return 8'd0;
        endcase
    endfunction

    assign reserved_w = (cmd_op >= 4'd14);
    assign final_w    = final_byte(cmd_op);
    assign cmd_ready  = (state == IDLE);
    assign busy       = ~cmd_ready;

`ifdef CSI_ENCODER_PARAM_EN
    logic [7:0] hund_q;
    logic [7:0] tens_q;
    logic [7:0] hund_w;
    logic [7:0] tens_w;
    logic [6:0] eff_param;
    logic [6:0] rem_w;
    logic [6:0] tens_val;
    logic [6:0] ones_val;

    // Split the incoming parameter into ASCII digits so they can be latched at acceptance.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first; a path that
        // leaves one unassigned would infer a latch.
        eff_param = cmd_param;
        rem_w     = 7'd0;
        tens_val  = 7'd0;
        ones_val  = 7'd0;
        hund_w    = ASCII_ZERO;
        tens_w    = ASCII_ZERO;
        ones_w    = ASCII_ZERO;
        ndig_w    = 2'd0;
        // Opcodes 11 and 12 never carry a parameter.
        if (cmd_op == 4'd11 || cmd_op == 4'd12)
            eff_param = 7'd0;
        rem_w    = (eff_param >= 7'd100) ? (eff_param - 7'd100) : eff_param;
        tens_val = rem_w / 7'd10;
        ones_val = rem_w % 7'd10;
        hund_w   = (eff_param >= 7'd100) ? 8'd49 : ASCII_ZERO;
        tens_w   = ASCII_ZERO + {1'b0, tens_val};
        if (cmd_op == OP_DEL) begin
            // Delete key is always ESC [ 3 ~ regardless of the parameter.
            ones_w = ASCII_THREE;
            ndig_w = 2'd1;
        end else begin
            ones_w = ASCII_ZERO + {1'b0, ones_val};
            if (eff_param >= 7'd100)     ndig_w = 2'd3;
            else if (eff_param >= 7'd10) ndig_w = 2'd2;
            else if (eff_param != 7'd0)  ndig_w = 2'd1;
            else                         ndig_w = 2'd0;
        end
    end
`else
    logic unused_param;
    assign unused_param = ^cmd_param;
    // Only the delete key carries a digit when parameters are disabled.
    assign ones_w = ASCII_THREE;
    assign ndig_w = (cmd_op == OP_DEL) ? 2'd1 : 2'd0;
`endif

    // Sequencer: accept in IDLE, then step ESC -> BRK -> digits -> FINAL on each byte transfer.
    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_data  <= 8'd0;
            done      <= 1'b0;
            err       <= 1'b0;
            final_q   <= 8'd0;
            ones_q    <= 8'd0;
            ndig_q    <= 2'd0;
`ifdef CSI_ENCODER_PARAM_EN
            hund_q    <= 8'd0;
            tens_q    <= 8'd0;
`endif
        end else begin
            // NOTE: state is updated with non-blocking assignments so every register
            // samples the pre-edge values of the others, whatever the statement order.
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        if (reserved_w) begin
                            err <= 1'b1;
                        end else begin
                            state     <= ESC;
                            out_valid <= 1'b1;
                            out_data  <= ASCII_ESC;
                            final_q   <= final_w;
                            ones_q    <= ones_w;
                            ndig_q    <= ndig_w;
`ifdef CSI_ENCODER_PARAM_EN
                            hund_q    <= hund_w;
                            tens_q    <= tens_w;
`endif
                        end
                    end
                end
                ESC: begin
                    if (out_ready) begin
                        state    <= BRK;
                        out_data <= ASCII_BRK;
                    end
                end
                BRK: begin
                    if (out_ready) begin
                        case (ndig_q)
`ifdef CSI_ENCODER_PARAM_EN
                            2'd3: begin state <= HUND; out_data <= hund_q; end
                            2'd2: begin state <= TENS; out_data <= tens_q; end
`endif
                            2'd1:    begin state <= ONES;  out_data <= ones_q;  end
                            default: begin state <= FINAL; out_data <= final_q; end
                        endcase
                    end
                end
`ifdef CSI_ENCODER_PARAM_EN
                HUND: begin
                    if (out_ready) begin
                        state    <= TENS;
                        out_data <= tens_q;
                    end
                end
                TENS: begin
                    if (out_ready) begin
                        state    <= ONES;
                        out_data <= ones_q;
                    end
                end
`endif
                ONES: begin
                    if (out_ready) begin
                        state    <= FINAL;
                        out_data <= final_q;
                    end
                end
                FINAL: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        out_data  <= 8'd0;
                        done      <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    out_data  <= 8'd0;
                end
            endcase
        end
    end

endmodule

// File: doc/csi_encoder.md
CSI_ENCODER -- requirements
Module: csi_encoder

Interface
REQ-001 SHALL have ports, clock and reset first, reset _rst, asynchronous, active-low; clock clk:
- clk  in  1  system clock, all state on rising edge
- _rst  in  1  asynchronous active-low reset
- cmd_valid  in  1  command request
- cmd_op  in  4  opcode (REQ-006)
- cmd_param  in  7  numeric parameter 0..127
- cmd_ready  out  1  encoder can accept a command
- out_data  out  8  byte to terminal transmitter
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts byte
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse after final byte transfers
- err  out  1  one-cycle pulse on reserved opcode

Function
REQ-002 SHALL accept a command on a rising edge with cmd_valid=1 and cmd_ready=1, and latch cmd_op and cmd_param.
REQ-003 SHALL drive cmd_ready=1 only in state IDLE; busy SHALL be the inverse of cmd_ready.
REQ-004 SHALL transfer a byte on each edge with out_valid=1 and out_ready=1; out_data SHALL stay stable while out_valid=1 and out_ready=0.
REQ-005 SHALL use states IDLE, ESC, BRK, HUND, TENS, ONES, FINAL; after acceptance: ESC (27), BRK ('[' 91), then digit states, then FINAL, each advancing only on a transfer; a FINAL transfer returns to IDLE.
REQ-006 SHALL map final bytes: 0 'C'(67), 1 'D'(68), 2 'E'(69), 3 'F'(70), 4 'G'(71), 5 'H'(72), 6 'J'(74), 7 'K'(75), 8 'S'(83), 9 'T'(84), 10 'f'(102), 11 's'(115), 12 'u'(117), 13 '~'(126).
REQ-007 SHALL emit the parameter as ASCII decimal ('0'=48), most-significant first, without leading zeros; HUND skipped when param<100, TENS skipped when param<10.
REQ-008 SHALL emit no digits when param=0; ESC and BRK then go directly to FINAL.
REQ-009 SHALL ignore cmd_param for opcodes 11 and 12 (no digits).
REQ-010 SHALL emit, for opcode 13, the fixed digit '3'(51) and ignore cmd_param: ESC [ 3 ~.
REQ-011 SHALL, for opcodes 14-15, accept the command, emit no bytes, stay in IDLE, and pulse err for one cycle following acceptance.
REQ-012 SHALL compute hundreds/tens/ones digits at acceptance and hold them in registers; maximum sequence length 6 bytes (param 100-127).
REQ-013 SHALL present the ESC byte with out_valid=1 in the cycle after acceptance (latency 1 cycle).
REQ-014 SHALL pulse done for one cycle on the edge after the FINAL transfer, coincident with cmd_ready returning to 1; a new command MAY be accepted in that same cycle.
REQ-015 SHALL ignore cmd_valid while busy=1; the requester holds cmd_valid until cmd_ready.
REQ-016 SHALL ignore out_ready while out_valid=0.

Reset
REQ-017 SHALL, on _rst=0 at any time including mid-sequence, force IDLE and clear the latched command immediately, without waiting for clk.
REQ-018 SHALL reset outputs to: cmd_ready=1, busy=0, out_valid=0, out_data=0, done=0, err=0.
REQ-019 SHALL never emit a partial-sequence remnant after reset release; the first post-reset byte is always ESC of a newly accepted command.

Configuration
REQ-020 SHALL honour macro CSI_ENCODER_PARAM_EN: when defined, digits per REQ-007..REQ-010; when undefined, HUND/TENS/ONES logic is omitted, cmd_param is ignored, and every sequence is ESC [ <final> except opcode 13, which remains ESC [ 3 ~.

Verification
REQ-021 SHALL cover: macro defined, op=5 param=0, out_ready=1 -> bytes 27,91,72; done pulse on the cycle after the third transfer.
REQ-022 SHALL cover: op=0 param=127 with out_ready=1 -> 27,91,49,50,55,67; op=0 param=7 -> 27,91,55,67.
REQ-023 SHALL cover: op=13 param=99 with out_ready toggling 1,0,0,1 -> 27,91,51,126, out_data held while stalled, no duplicate or lost byte.
REQ-024 SHALL cover: op=15 -> no out_valid, err=1 for one cycle, cmd_ready=1 on the next cycle.
REQ-025 SHALL cover: _rst asserted after the second byte of op=1 param=45 -> out_valid=0 immediately; a subsequent op=7 param=2 yields 27,91,50,75.
REQ-026 SHALL cover: macro undefined, op=4 param=80 -> 27,91,71; back-to-back commands with cmd_valid held -> second ESC follows in the cycle after the done pulse.
